// File: rtl/timing_ref_monitor.sv
// timing_ref_monitor: windowed edge-count loss monitor for N_REF async references
// with hysteresis qualification and a FREERUN/LOCKED/HOLDOVER priority selector.
module timing_ref_monitor #(
    parameter int N_REF     = 11,
    parameter int WIN_CYC   = 1000,
    parameter int MIN_EDGES = 2,
    parameter int QUAL_WIN  = 4,
    parameter int HOLD_WINS = 125000,
    parameter int SEL_W     = (N_REF > 1) ? $clog2(N_REF) : 1
) (
    input  logic               clk_125m,
    input  logic               rst,
    input  logic [N_REF-1:0]   ref_clk_in,
    input  logic [N_REF-1:0]   ref_en,
    input  logic [N_REF*4-1:0] ref_prio,
    input  logic               revertive,
    input  logic               force_en,
    input  logic [SEL_W-1:0]   force_sel,
    output logic [N_REF-1:0]   clk_loss,
    output logic [SEL_W-1:0]   sel_ref,
    output logic               sel_valid,
    output logic [1:0]         state,
    output logic               switch_pulse,
    output logic               win_tick
);

    localparam int WIN_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int EDGE_W = (MIN_EDGES > 0) ? $clog2(MIN_EDGES + 1) : 1;
    localparam int QUAL_W = (QUAL_WIN > 0) ? $clog2(QUAL_WIN + 1) : 1;
    localparam int HOLD_W = (HOLD_WINS > 0) ? $clog2(HOLD_WINS + 1) : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYC - 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX  = EDGE_W'(MIN_EDGES);
    localparam logic [QUAL_W-1:0] QUAL_MAX  = QUAL_W'(QUAL_WIN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINS - 1);

    typedef enum logic [1:0] {
        ST_FREERUN  = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } fsm_e;

    logic [N_REF-1:0]  s1_q;
    logic [N_REF-1:0]  s2_q;
    logic [N_REF-1:0]  s3_q;
    logic [N_REF-1:0]  rise;

    logic [WIN_W-1:0]  win_q;
    logic [WIN_W-1:0]  win_d;
    logic              win_end;

    logic [EDGE_W-1:0] edge_q   [N_REF];
    logic [EDGE_W-1:0] edge_d   [N_REF];
    logic [EDGE_W-1:0] edge_sum [N_REF];
    logic [N_REF-1:0]  good;

    logic [QUAL_W-1:0] qual_q [N_REF];
    logic [QUAL_W-1:0] qual_d [N_REF];
    logic [N_REF-1:0]  loss_q;
    logic [N_REF-1:0]  loss_d;

    logic [3:0]        prio [N_REF];
    logic [N_REF-1:0]  elig;

    logic              cand_found;
    logic [SEL_W-1:0]  cand_idx;
    logic [3:0]        cand_prio;
    logic              cur_ok;
    logic [3:0]        cur_prio;
    logic              frc_ok;
    logic [3:0]        frc_prio;
    logic              frc_valid;
    logic              tgt_valid;
    logic [SEL_W-1:0]  tgt_idx;
    logic [3:0]        tgt_prio;

    fsm_e              state_q;
    fsm_e              state_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              pulse_q;
    logic              pulse_d;

    // References are treated as data: three flops, rising edge seen as s2 & ~s3.
    always_ff @(posedge clk_125m) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= ref_clk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign win_end = (win_q == WIN_LAST);
    assign win_d   = win_end ? '0 : win_q + 1'b1;

    // An edge landing in the terminal cycle still belongs to the closing window.
    always_comb begin
        good = '0;
        for (int i = 0; i < N_REF; i++) begin
            if (edge_q[i] == EDGE_MAX) begin
                edge_sum[i] = EDGE_MAX;
            end else begin
                edge_sum[i] = edge_q[i] + EDGE_W'(rise[i]);
            end
            good[i]   = (edge_sum[i] >= EDGE_MAX) & ref_en[i];
            edge_d[i] = win_end ? '0 : edge_sum[i];
        end
    end

    always_comb begin
        loss_d = loss_q;
        for (int i = 0; i < N_REF; i++) begin
            qual_d[i] = qual_q[i];
            if (win_end) begin
                if (!good[i]) begin
                    qual_d[i] = '0;
                    loss_d[i] = 1'b1;
                end else begin
                    if (qual_q[i] != QUAL_MAX) begin
                        qual_d[i] = qual_q[i] + 1'b1;
                    end
                    if (qual_d[i] == QUAL_MAX) begin
                        loss_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_125m) begin
        if (rst) begin
            win_q  <= '0;
            loss_q <= '1;
            for (int i = 0; i < N_REF; i++) begin
                edge_q[i] <= '0;
                qual_q[i] <= '0;
            end
        end else begin
            win_q  <= win_d;
            loss_q <= loss_d;
            for (int i = 0; i < N_REF; i++) begin
                edge_q[i] <= edge_d[i];
                qual_q[i] <= qual_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_REF; g++) begin : g_prio
        assign prio[g] = ref_prio[4*g +: 4];
        assign elig[g] = ref_en[g] & ~loss_q[g] & (prio[g] != 4'hf);
    end

    // Strict less-than keeps the lowest index on equal priority.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_prio  = 4'hf;
        for (int i = 0; i < N_REF; i++) begin
            if (elig[i] && (!cand_found || (prio[i] < cand_prio))) begin
                cand_found = 1'b1;
                cand_idx   = SEL_W'(i);
                cand_prio  = prio[i];
            end
        end
    end

    // Index matching keeps out-of-range selects from reading past N_REF.
    always_comb begin
        cur_ok   = 1'b0;
        cur_prio = 4'hf;
        frc_ok   = 1'b0;
        frc_prio = 4'hf;
        for (int i = 0; i < N_REF; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_ok   = ref_en[i] & ~loss_q[i];
                cur_prio = prio[i];
            end
            if (force_sel == SEL_W'(i)) begin
                frc_ok   = ref_en[i] & ~loss_q[i];
                frc_prio = prio[i];
            end
        end
    end

    assign frc_valid = force_en & frc_ok;
    assign tgt_valid = frc_valid | cand_found;
    assign tgt_idx   = frc_valid ? force_sel : cand_idx;
    assign tgt_prio  = frc_valid ? frc_prio : cand_prio;

    always_ff @(posedge clk_125m) begin
        if (rst) begin
            state_q <= ST_FREERUN;
            sel_q   <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_FREERUN: begin
                if (tgt_valid) begin
                    state_d = ST_LOCKED;
                    sel_d   = tgt_idx;
                end
            end
            ST_LOCKED: begin
                if (!cur_ok) begin
                    if (tgt_valid) begin
                        sel_d = tgt_idx;
                    end else begin
                        state_d = ST_HOLDOVER;
                        hold_d  = '0;
                    end
                end else if (frc_valid && (tgt_idx != sel_q)) begin
                    sel_d = tgt_idx;
                end else if (revertive && tgt_valid && (tgt_prio < cur_prio)) begin
                    sel_d = tgt_idx;
                end
            end
            ST_HOLDOVER: begin
                if (tgt_valid) begin
                    state_d = ST_LOCKED;
                    sel_d   = tgt_idx;
                end else if (win_end) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_FREERUN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_FREERUN;
            end
        endcase
    end

    always_comb begin
        pulse_d = (sel_d != sel_q) |
                  ((state_d == ST_LOCKED) & (state_q != ST_LOCKED));
    end

    assign clk_loss     = loss_q;
    assign sel_ref      = sel_q;
    assign sel_valid    = (state_q == ST_LOCKED);
    assign state        = state_q;
    assign switch_pulse = pulse_q;
    assign win_tick     = win_end;

endmodule

// File: tb/tb_timing_ref_monitor.sv
// tb_timing_ref_monitor: directed test-plan steps then random phases,
// checked every cycle against a window-level behavioural model.
module tb_timing_ref_monitor;

    localparam int N    = 4;
    localparam int WIN  = 64;
    localparam int MINE = 2;
    localparam int QW   = 3;
    localparam int HW   = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   ref_clk = '0;
    logic [N-1:0]   ref_en = '1;
    logic [4*N-1:0] ref_prio = '0;
    logic           revertive = 1'b1;
    logic           force_en = 1'b0;
    logic [1:0]     force_sel = '0;
    logic [N-1:0]   clk_loss;
    logic [1:0]     sel_ref;
    logic           sel_valid;
    logic [1:0]     state;
    logic           switch_pulse;
    logic           win_tick;

    timing_ref_monitor #(
        .N_REF(N), .WIN_CYC(WIN), .MIN_EDGES(MINE),
        .QUAL_WIN(QW), .HOLD_WINS(HW)
    ) dut (
        .clk_125m(clk), .rst(rst), .ref_clk_in(ref_clk),
        .ref_en(ref_en), .ref_prio(ref_prio), .revertive(revertive),
        .force_en(force_en), .force_sel(force_sel),
        .clk_loss(clk_loss), .sel_ref(sel_ref), .sel_valid(sel_valid),
        .state(state), .switch_pulse(switch_pulse), .win_tick(win_tick)
    );

    always #4 clk = ~clk;

    bit run [N];
    int half [N];
    int ph [N];

    // Model: t = non-reset edges since release; window k closes at edge k*WIN.
    int t;
    int ecnt [N][2];
    bit m_loss [N];
    int m_q [N];
    int m_state;
    int m_sel;
    bit m_pulse;
    int m_hold;
    bit m_inrst;

    int n_chk;
    int n_fail;

    function automatic int prio_of(int c);
        return int'(ref_prio[c*4 +: 4]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_edge();
        int cand;
        int tgt;
        int fs;
        int k;
        bit forced;
        bit healthy;
        m_inrst = rst;
        if (rst) begin
            t = 0;
            m_state = 0;
            m_sel = 0;
            m_pulse = 0;
            m_hold = 0;
            for (int c = 0; c < N; c++) begin
                m_loss[c] = 1;
                m_q[c] = 0;
                ecnt[c][0] = 0;
                ecnt[c][1] = 0;
            end
            return;
        end
        t++;
        cand = -1;
        for (int c = 0; c < N; c++) begin
            if (ref_en[c] && !m_loss[c] && prio_of(c) != 15) begin
                if (cand < 0 || prio_of(c) < prio_of(cand)) cand = c;
            end
        end
        fs = int'(force_sel);
        forced = force_en && fs < N && ref_en[fs] && !m_loss[fs];
        tgt = forced ? fs : cand;
        m_pulse = 0;
        case (m_state)
            0: begin
                if (tgt >= 0) begin
                    m_state = 1;
                    m_sel = tgt;
                    m_pulse = 1;
                end
            end
            1: begin
                healthy = ref_en[m_sel] && !m_loss[m_sel];
                if (!healthy) begin
                    if (tgt >= 0) begin
                        m_sel = tgt;
                        m_pulse = 1;
                    end else begin
                        m_state = 2;
                        m_hold = 0;
                    end
                end else if (tgt >= 0 && tgt != m_sel &&
                             (forced || (revertive &&
                              prio_of(tgt) < prio_of(m_sel)))) begin
                    m_sel = tgt;
                    m_pulse = 1;
                end
            end
            default: begin
                if (tgt >= 0) begin
                    m_state = 1;
                    m_sel = tgt;
                    m_pulse = 1;
                end else if (t % WIN == 0) begin
                    m_hold++;
                    if (m_hold == HW) m_state = 0;
                end
            end
        endcase
        if (t % WIN == 0) begin
            k = (t / WIN) % 2;
            for (int c = 0; c < N; c++) begin
                if (ecnt[c][k] >= MINE && ref_en[c]) begin
                    if (m_q[c] < QW) m_q[c]++;
                    if (m_q[c] == QW) m_loss[c] = 0;
                end else begin
                    m_q[c] = 0;
                    m_loss[c] = 1;
                end
                ecnt[c][k] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] el;
        bit wt;
        for (int c = 0; c < N; c++) el[c] = m_loss[c];
        wt = !m_inrst && (t % WIN == WIN - 1);
        chk("clk_loss", 32'(clk_loss), 32'(el));
        chk("sel_ref", 32'(sel_ref), 32'(m_sel));
        chk("state", 32'(state), 32'(m_state));
        chk("sel_valid", 32'(sel_valid), 32'(m_state == 1));
        chk("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
        chk("win_tick", 32'(win_tick), 32'(wt));
    endtask

    // A rise driven before edge t+1 is counted by the design at edge t+3.
    task automatic step();
        int w;
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                ref_clk[c] = 1'b0;
                ph[c] = half[c];
            end else if (run[c]) begin
                ph[c]--;
                if (ph[c] <= 0) begin
                    ph[c] = half[c];
                    ref_clk[c] = ~ref_clk[c];
                    if (ref_clk[c]) begin
                        w = (t + 3 + WIN - 1) / WIN;
                        ecnt[c][w % 2]++;
                    end
                end
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        t = 0;
        ref_prio = {4'd0, 4'd1, 4'd2, 4'd3};
        for (int c = 0; c < N; c++) begin
            half[c] = $urandom_range(14, 10);
            ph[c] = half[c];
            run[c] = 1;
        end

        rst = 1'b1;
        step();
        step();
        chk("rst_loss", 32'(clk_loss), 32'hF);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(sel_valid), 32'd0);
        rst = 1'b0;

        run_cyc(3 * WIN - 1);
        chk("t1_loss_pre", 32'(clk_loss), 32'hF);
        step();
        chk("t1_loss_clr", 32'(clk_loss), 32'h0);
        step();
        chk("t1_state", 32'(state), 32'd1);
        chk("t1_sel", 32'(sel_ref), 32'd3);
        chk("t1_pulse", 32'(switch_pulse), 32'd1);
        step();
        chk("t1_pulse_off", 32'(switch_pulse), 32'd0);

        run[3] = 0;
        run_cyc(3 * WIN);
        chk("t2_loss3", 32'(clk_loss[3]), 32'd1);
        chk("t2_sel", 32'(sel_ref), 32'd2);

        revertive = 1'b1;
        run[3] = 1;
        run_cyc(5 * WIN);
        chk("t3_rev_sel", 32'(sel_ref), 32'd3);
        revertive = 1'b0;
        run[3] = 0;
        run_cyc(3 * WIN);
        chk("t3_drop_sel", 32'(sel_ref), 32'd2);
        run[3] = 1;
        run_cyc(5 * WIN);
        chk("t3_nonrev_sel", 32'(sel_ref), 32'd2);
        chk("t3_nonrev_loss3", 32'(clk_loss[3]), 32'd0);

        for (int c = 0; c < N; c++) run[c] = 0;
        run_cyc(3 * WIN);
        chk("t4_hold_state", 32'(state), 32'd2);
        chk("t4_hold_sel", 32'(sel_ref), 32'd2);
        run_cyc(4 * WIN);
        chk("t4_free_state", 32'(state), 32'd0);
        chk("t4_free_valid", 32'(sel_valid), 32'd0);
        revertive = 1'b1;
        for (int c = 0; c < N; c++) run[c] = 1;
        run_cyc(5 * WIN);
        chk("t4_relock_sel", 32'(sel_ref), 32'd3);

        force_en = 1'b1;
        force_sel = 2'd0;
        step();
        chk("t5_force_sel", 32'(sel_ref), 32'd0);
        chk("t5_force_pulse", 32'(switch_pulse), 32'd1);
        run[0] = 0;
        run_cyc(3 * WIN);
        chk("t5_fallback_sel", 32'(sel_ref), 32'd3);
        force_en = 1'b0;
        run[0] = 1;
        run_cyc(5 * WIN);

        ref_en = 4'b0111;
        run_cyc(WIN + 2);
        chk("t6_en_loss3", 32'(clk_loss[3]), 32'd1);
        chk("t6_en_sel", 32'(sel_ref), 32'd2);
        ref_en = 4'hF;
        run_cyc(20);
        rst = 1'b1;
        step();
        chk("t6_rst_loss", 32'(clk_loss), 32'hF);
        chk("t6_rst_sel", 32'(sel_ref), 32'd0);
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_tick", 32'(win_tick), 32'd0);
        rst = 1'b0;

        for (int it = 0; it < 60; it++) begin
            for (int c = 0; c < N; c++) begin
                run[c] = ($urandom_range(3, 0) != 0);
                half[c] = $urandom_range(40, 3);
            end
            ref_en = 4'($urandom) | 4'($urandom);
            ref_prio = 16'($urandom);
            revertive = 1'($urandom);
            force_en = ($urandom_range(3, 0) == 0);
            force_sel = 2'($urandom);
            if ($urandom_range(19, 0) == 0) begin
                rst = 1'b1;
                run_cyc(2);
                rst = 1'b0;
            end
            run_cyc($urandom_range(2 * WIN, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_ref_monitor.md
# timing_ref_monitor

Parametrised reference-clock monitor and selector for the timing subsystem. It samples N_REF asynchronous reference clocks in the clk_125m domain and counts their edges over a fixed window. From those counts it qualifies loss and recovery with hysteresis, and it picks the active reference by programmable priority through a FREERUN/LOCKED/HOLDOVER state machine. It extends per-channel loss flags with qualification, forced selection, revertive/non-revertive switching and a holdover timeout.

## Interface
- N_REF, 11, number of monitored reference clocks
- WIN_CYC, 1000, window length in clk_125m cycles (8 µs)
- MIN_EDGES, 2, minimum rising edges per window for a good window
- QUAL_WIN, 4, consecutive good windows needed to clear loss
- HOLD_WINS, 125000, windows spent in HOLDOVER before FREERUN (1 s)
- SEL_W, $clog2(N_REF), select width (derived)

- clk_125m  in  1  system clock; one clock only
- rst  in  1  synchronous, active-high reset
- ref_clk_in  in  N_REF  asynchronous reference clocks, sampled as data
- ref_en  in  N_REF  per-channel enable
- ref_prio  in  N_REF×4  per-channel priority; 0 highest; 15 never selected
- revertive  in  1  1 = return to a better-priority reference when it recovers
- force_en  in  1  forced-selection enable
- force_sel  in  SEL_W  forced channel index
- clk_loss  out  N_REF  per-channel qualified loss flag
- sel_ref  out  SEL_W  active reference index
- sel_valid  out  1  high when state is LOCKED
- state  out  2  0 = FREERUN, 1 = LOCKED, 2 = HOLDOVER
- switch_pulse  out  1  one-cycle pulse when sel_ref changes or LOCKED is entered
- win_tick  out  1  one-cycle pulse on the window terminal cycle

## Operation
- Per channel: 2-FF synchroniser, then a third register. Rising edge = s2 & ~s3. Guaranteed detection for reference frequency ≤ 25 MHz.
- Shared window counter runs 0..WIN_CYC-1 and wraps. win_end = count WIN_CYC-1, and win_tick = win_end.
- Per-channel edge counter saturates at MIN_EDGES.
  - An edge in the win_end cycle counts toward the closing window.
  - The counter restarts at 0 in the next cycle.
- At win_end, good[i] = (edges ≥ MIN_EDGES) & ref_en[i].
- Loss and recovery:
  - Bad window: clk_loss[i] set immediately and qual_cnt[i] cleared.
  - Good window: qual_cnt[i] increments, saturating at QUAL_WIN. clk_loss[i] clears when qual_cnt reaches QUAL_WIN.
  - ref_en[i] = 0 forces clk_loss[i] = 1 at the next win_end.
- Candidate: the channel with ref_en & ~clk_loss & prio ≠ 15 and the lowest prio value. Ties go to the lowest index.
- Forced selection is valid when force_en & ref_en[force_sel] & ~clk_loss[force_sel] & force_sel < N_REF. When valid, the forced channel replaces the candidate.
- FSM, evaluated every cycle on registered clk_loss:
  - FREERUN: target exists → LOCKED, sel_ref = target, switch_pulse.
  - LOCKED, sel_ref lost or disabled: target exists → switch to target and stay LOCKED; no target → HOLDOVER, with sel_ref held.
  - LOCKED, target valid because of force and target ≠ sel_ref → switch.
  - LOCKED, revertive = 1 and target prio < prio[sel_ref] → switch. Non-revertive holds sel_ref while it is healthy.
  - HOLDOVER: target exists → LOCKED, switch_pulse. The hold counter increments on each win_tick; at HOLD_WINS → FREERUN.
- Hold counter clears on every entry to HOLDOVER.
- ref_prio changes take effect on the next cycle.

## Timing
- Reset values:
  - clk_loss = all 1
  - qual_cnt, edge counters, window counter, hold counter = 0
  - state = FREERUN, sel_ref = 0, sel_valid = 0, switch_pulse = 0, win_tick = 0
- Input edge to edge-counter increment: 3 cycles.
- win_end cycle N → clk_loss valid at N+1 → FSM / sel_ref / state valid at N+2. switch_pulse is high in cycle N+2 only.
- Loss detection latency is at most 2 windows + 2 cycles. Recovery needs QUAL_WIN consecutive good windows.
- If loss of the current reference and a better candidate's recovery land on the same win_end, resolve in a single transition to that candidate with one switch_pulse.
- rst mid-operation returns to reset values on the next edge. Loss must then be re-qualified from scratch.
- All counters saturate or wrap only as specified. No arithmetic overflow at any parameter value.

## Test plan
Bench parameters: N_REF = 4, WIN_CYC = 64, MIN_EDGES = 2, QUAL_WIN = 3, HOLD_WINS = 4. All refs toggle every 100 ns (5 MHz). Priorities = {3, 2, 1, 0} for channels 0..3.

1. Reset release, all refs running → clk_loss = 4'hF for 3 windows, then 4'h0. One cycle later: state = 1, sel_ref = 3, one switch_pulse.
2. Stop ref 3 → clk_loss[3] = 1 within 2 windows + 2 cycles. sel_ref = 2 with one switch_pulse.
3. Restart ref 3, revertive = 1 → after 3 good windows sel_ref = 3. With revertive = 0 → sel_ref stays 2.
4. Stop all refs → state = 2 with sel_ref held. After 4 win_ticks, state = 0 and sel_valid = 0.
5. force_en = 1, force_sel = 0 while LOCKED on 3 → sel_ref = 0 in 1 cycle. Then stop ref 0 → falls back to 3.
6. ref_en = 4'b0111 while locked on 3 → clk_loss[3] = 1 at the next win_end, sel_ref = 2. Asserting rst mid-window → all outputs return to reset values next cycle.
